axis_fork_sched: RTL and testbench

AXIS_FORK_SCHED -- requirements
Module: axis_fork_sched

---
 rtl/axis_fork_sched.sv | 143 ++++++++++++++
 tb/tb_axis_fork_sched.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_fork_sched.sv
// Job scheduler for an AXI-Stream fork arbiter: forks a commanded number of frames, then drains.
// Optional stall watchdog enabled by defining FORK_SCHED_TIMEOUT_EN.
module axis_fork_sched #(
  parameter int M_COUNT        = 3,
  parameter int CNT_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [CNT_WIDTH-1:0] cmd_frames,
  input  logic [M_COUNT-1:0]   cmd_mask,
  output logic                 fork_enable,
  output logic [M_COUNT-1:0]   fork_mask,
  input  logic                 fork_done,
  input  logic                 mon_tvalid,
  input  logic                 mon_tready,
  input  logic                 mon_tlast,
  output logic                 busy,
  output logic                 done_pulse,
  output logic [CNT_WIDTH-1:0] frame_cnt,
  output logic                 err_timeout
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t               state;
  logic [CNT_WIDTH-1:0] frames;
  logic [CNT_WIDTH-1:0] cnt_inc;
  logic                 hs;
  logic                 hs_last;
  logic                 stall_hit;

  assign hs      = mon_tvalid & mon_tready;
  assign hs_last = hs & mon_tlast;
  assign cnt_inc = frame_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  // Job FSM; every output is registered alongside the state it belongs to.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cmd_ready   <= 1'b0;
      fork_enable <= 1'b0;
      fork_mask   <= '0;
      busy        <= 1'b0;
      done_pulse  <= 1'b0;
      frame_cnt   <= '0;
      frames      <= '0;
    end else begin
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            frames    <= cmd_frames;
            fork_mask <= cmd_mask;
            frame_cnt <= '0;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            if (cmd_frames != '0) begin
              state       <= RUN;
              fork_enable <= 1'b1;
            end else begin
              state      <= DONE;
              done_pulse <= 1'b1;
            end
          end
        end
        RUN: begin
          if (hs_last) begin
            frame_cnt <= cnt_inc;
            if (cnt_inc == frames) begin
              state       <= DRAIN;
              fork_enable <= 1'b0;
            end
          end else if (stall_hit) begin
            state       <= DONE;
            fork_enable <= 1'b0;
            done_pulse  <= 1'b1;
          end
        end
        DRAIN: begin
          if (fork_done || stall_hit) begin
            state      <= DONE;
            done_pulse <= 1'b1;
          end
        end
        DONE: begin
          state      <= IDLE;
          done_pulse <= 1'b0;
          busy       <= 1'b0;
          cmd_ready  <= 1'b1;
        end
        default: begin
          state       <= IDLE;
          cmd_ready   <= 1'b0;
          fork_enable <= 1'b0;
          busy        <= 1'b0;
          done_pulse  <= 1'b0;
        end
      endcase
    end
  end

`ifdef FORK_SCHED_TIMEOUT_EN
  localparam int SW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [SW-1:0] stall_cnt;
  logic          active;
  logic          drain_exit;

  assign active     = (state == RUN) || (state == DRAIN);
  assign drain_exit = (state == DRAIN) && fork_done;
  // A normal drain completion on the same cycle wins over the watchdog.
  assign stall_hit  = active && !hs && !drain_exit && (stall_cnt == SW'(TIMEOUT_CYCLES - 1));

  // Stall counter: restarts on any beat and whenever the state changes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (!active || hs || drain_exit || stall_hit) begin
      stall_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + {{(SW-1){1'b0}}, 1'b1};
    end
  end

  // Sticky abort flag, cleared only by the next accepted command.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_timeout <= 1'b0;
    end else if (state == IDLE && cmd_valid && cmd_ready) begin
      err_timeout <= 1'b0;
    end else if (stall_hit) begin
      err_timeout <= 1'b1;
    end
  end
`else
  assign stall_hit   = 1'b0;
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_axis_fork_sched.sv
// Scenario bench for axis_fork_sched; expected job results go through a scoreboard queue.
// The timeout scenario runs when FORK_SCHED_TIMEOUT_EN is defined.
module tb_axis_fork_sched;

  localparam int M  = 3;
  localparam int CW = 16;
  localparam int TO = 16;

  typedef struct packed {
    logic [CW-1:0] frames;
    logic [M-1:0]  mask;
  } job_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [CW-1:0] cmd_frames = '0;
  logic [M-1:0]  cmd_mask = '0;
  logic          fork_enable;
  logic [M-1:0]  fork_mask;
  logic          fork_done = 1'b0;
  logic          mon_tvalid = 1'b0;
  logic          mon_tready = 1'b0;
  logic          mon_tlast = 1'b0;
  logic          busy;
  logic          done_pulse;
  logic [CW-1:0] frame_cnt;
  logic          err_timeout;

  int   total = 0;
  int   bad = 0;
  int   done_seen = 0;
  int   jobs_expected = 0;
  job_t sb[$];

  axis_fork_sched #(.M_COUNT(M), .CNT_WIDTH(CW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_frames(cmd_frames), .cmd_mask(cmd_mask), .fork_enable(fork_enable),
    .fork_mask(fork_mask), .fork_done(fork_done), .mon_tvalid(mon_tvalid),
    .mon_tready(mon_tready), .mon_tlast(mon_tlast), .busy(busy),
    .done_pulse(done_pulse), .frame_cnt(frame_cnt), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // Scoreboard: each completion strobe retires the oldest expected job.
  always @(negedge clk) begin
    if (rst_n && done_pulse === 1'b1) begin
      job_t exp_j;
      done_seen++;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected_done: got done_pulse with empty scoreboard at %0t", $time);
      end else begin
        exp_j = sb.pop_front();
        if (frame_cnt !== exp_j.frames || fork_mask !== exp_j.mask) begin
          bad++;
          $display("FAIL sb_job: frame_cnt=%0d fork_mask=%b expected frame_cnt=%0d fork_mask=%b",
                   frame_cnt, fork_mask, exp_j.frames, exp_j.mask);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [CW-1:0] f, input logic [M-1:0] m, input logic expect_done);
    cmd_valid  = 1'b1;
    cmd_frames = f;
    cmd_mask   = m;
    if (expect_done) begin
      job_t j;
      j.frames = (f > TO[CW-1:0]) ? f : f;
      j.mask   = m;
      sb.push_back(j);
      jobs_expected++;
    end
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic beat(input logic last);
    mon_tvalid = 1'b1;
    mon_tready = 1'b1;
    mon_tlast  = last;
    step();
    mon_tvalid = 1'b0;
    mon_tready = 1'b0;
    mon_tlast  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    total++;
    if ({cmd_ready, fork_enable, fork_mask, busy, done_pulse, frame_cnt, err_timeout} !== '0) begin
      bad++;
      $display("FAIL reset_vals: rdy=%b en=%b mask=%b busy=%b dp=%b cnt=%0d err=%b expected all 0",
               cmd_ready, fork_enable, fork_mask, busy, done_pulse, frame_cnt, err_timeout);
    end
    rst_n = 1'b1;
    step();
    total++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: cmd_ready=%b busy=%b expected 1 0", cmd_ready, busy);
    end
  endtask

  task automatic test_basic();
    issue(16'd3, 3'b101, 1'b1);
    total++;
    if (fork_enable !== 1'b1 || fork_mask !== 3'b101 || cmd_ready !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL basic_start: en=%b mask=%b rdy=%b busy=%b expected 1 101 0 1",
               fork_enable, fork_mask, cmd_ready, busy);
    end
    for (int i = 0; i < 3; i++) begin
      beat(1'b1);
      total++;
      if (frame_cnt !== CW'(i + 1) || fork_enable !== (i < 2)) begin
        bad++;
        $display("FAIL basic_tlast%0d: cnt=%0d en=%b expected cnt=%0d en=%b",
                 i, frame_cnt, fork_enable, i + 1, (i < 2));
      end
      if (i < 2) begin
        step();
        total++;
        if (fork_enable !== 1'b1) begin
          bad++;
          $display("FAIL basic_gap%0d: en=%b expected 1", i, fork_enable);
        end
      end
    end
    step();
    total++;
    if (fork_enable !== 1'b0 || busy !== 1'b1 || done_pulse !== 1'b0) begin
      bad++;
      $display("FAIL basic_drain: en=%b busy=%b dp=%b expected 0 1 0", fork_enable, busy, done_pulse);
    end
    fork_done = 1'b1;
    step();
    fork_done = 1'b0;
    total++;
    if (done_pulse !== 1'b1 || fork_enable !== 1'b0) begin
      bad++;
      $display("FAIL basic_done: dp=%b en=%b expected 1 0", done_pulse, fork_enable);
    end
    step();
    total++;
    if (done_pulse !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1 ||
        fork_mask !== 3'b101 || frame_cnt !== 16'd3) begin
      bad++;
      $display("FAIL basic_hold: dp=%b busy=%b rdy=%b mask=%b cnt=%0d expected 0 0 1 101 3",
               done_pulse, busy, cmd_ready, fork_mask, frame_cnt);
    end
  endtask

  task automatic test_zero_frames();
    issue(16'd0, 3'b011, 1'b1);
    total++;
    if (done_pulse !== 1'b1 || fork_enable !== 1'b0 || frame_cnt !== 16'd0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL zero_done: dp=%b en=%b cnt=%0d busy=%b expected 1 0 0 1",
               done_pulse, fork_enable, frame_cnt, busy);
    end
    step();
    total++;
    if (done_pulse !== 1'b0 || fork_enable !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL zero_idle: dp=%b en=%b rdy=%b expected 0 0 1", done_pulse, fork_enable, cmd_ready);
    end
  endtask

  task automatic test_drain_ignores();
    logic [4:0] pat;
    pat = 5'b10100;
    issue(16'd2, 3'b110, 1'b1);
    for (int i = 4; i >= 0; i--) beat(pat[i]);
    total++;
    if (frame_cnt !== 16'd2 || fork_enable !== 1'b0) begin
      bad++;
      $display("FAIL drain_count: cnt=%0d en=%b expected 2 0", frame_cnt, fork_enable);
    end
    for (int i = 0; i < 3; i++) beat(1'b1);
    total++;
    if (frame_cnt !== 16'd2 || busy !== 1'b1 || done_pulse !== 1'b0) begin
      bad++;
      $display("FAIL drain_no_inc: cnt=%0d busy=%b dp=%b expected 2 1 0", frame_cnt, busy, done_pulse);
    end
    fork_done = 1'b1;
    step();
    fork_done = 1'b0;
    step();
    beat(1'b1);
    total++;
    if (frame_cnt !== 16'd2 || busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_no_inc: cnt=%0d busy=%b expected 2 0", frame_cnt, busy);
    end
  endtask

  task automatic test_reset_mid_job();
    issue(16'd3, 3'b111, 1'b0);
    beat(1'b1);
    total++;
    if (frame_cnt !== 16'd1 || fork_enable !== 1'b1) begin
      bad++;
      $display("FAIL mid_pre: cnt=%0d en=%b expected 1 1", frame_cnt, fork_enable);
    end
    rst_n = 1'b0;
    step();
    total++;
    if (fork_enable !== 1'b0 || frame_cnt !== 16'd0 || done_pulse !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: en=%b cnt=%0d dp=%b busy=%b expected 0 0 0 0",
               fork_enable, frame_cnt, done_pulse, busy);
    end
    rst_n = 1'b1;
    step();
    issue(16'd1, 3'b010, 1'b1);
    total++;
    if (fork_enable !== 1'b1 || fork_mask !== 3'b010) begin
      bad++;
      $display("FAIL mid_new_cmd: en=%b mask=%b expected 1 010", fork_enable, fork_mask);
    end
    beat(1'b1);
    fork_done = 1'b1;
    step();
    fork_done = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    job_t j;
    cmd_valid  = 1'b1;
    cmd_frames = 16'd0;
    cmd_mask   = 3'b001;
    j.frames = 16'd0;
    j.mask   = 3'b001;
    sb.push_back(j);
    jobs_expected++;
    step();
    total++;
    if (done_pulse !== 1'b1 || cmd_ready !== 1'b0) begin
      bad++;
      $display("FAIL b2b_first: dp=%b rdy=%b expected 1 0", done_pulse, cmd_ready);
    end
    cmd_mask = 3'b100;
    j.mask   = 3'b100;
    sb.push_back(j);
    jobs_expected++;
    step();
    total++;
    if (done_pulse !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL b2b_gap: dp=%b rdy=%b busy=%b expected 0 1 0", done_pulse, cmd_ready, busy);
    end
    step();
    cmd_valid = 1'b0;
    total++;
    if (done_pulse !== 1'b1 || fork_mask !== 3'b100) begin
      bad++;
      $display("FAIL b2b_second: dp=%b mask=%b expected 1 100", done_pulse, fork_mask);
    end
    step();
  endtask

`ifdef FORK_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    int early;
    early = 0;
    issue(16'd4, 3'b111, 1'b1);
    sb[sb.size()-1].frames = 16'd0;
    for (int i = 1; i < TO; i++) begin
      if (fork_enable !== 1'b1 || err_timeout !== 1'b0 || done_pulse !== 1'b0) early++;
      step();
    end
    total++;
    if (early != 0 || fork_enable !== 1'b1) begin
      bad++;
      $display("FAIL to_wait: early_cycles=%0d en=%b expected 0 1", early, fork_enable);
    end
    step();
    total++;
    if (err_timeout !== 1'b1 || done_pulse !== 1'b1 || fork_enable !== 1'b0) begin
      bad++;
      $display("FAIL to_fire: err=%b dp=%b en=%b expected 1 1 0", err_timeout, done_pulse, fork_enable);
    end
    step();
    issue(16'd0, 3'b001, 1'b1);
    total++;
    if (err_timeout !== 1'b0) begin
      bad++;
      $display("FAIL to_clear: err=%b expected 0", err_timeout);
    end
    step();
  endtask
`else
  task automatic test_no_timeout();
    int wrong;
    wrong = 0;
    issue(16'd1, 3'b001, 1'b1);
    beat(1'b1);
    for (int i = 0; i < 10000; i++) begin
      if (busy !== 1'b1 || err_timeout !== 1'b0 || fork_enable !== 1'b0 || done_pulse !== 1'b0) wrong++;
      step();
    end
    total++;
    if (wrong != 0) begin
      bad++;
      $display("FAIL drain_wait: bad_cycles=%0d expected 0", wrong);
    end
    fork_done = 1'b1;
    step();
    fork_done = 1'b0;
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_zero_frames();
    test_drain_ignores();
    test_reset_mid_job();
    test_back_to_back();
`ifdef FORK_SCHED_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    step();
    total++;
    if (done_seen != jobs_expected || sb.size() != 0) begin
      bad++;
      $display("FAIL job_count: done_pulses=%0d pending=%0d expected %0d 0",
               done_seen, sb.size(), jobs_expected);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
